// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: bridges the CPU control FSM to a single-beat external
// memory channel. One read or write is in flight at a time. The control FSM
// is frozen through 'hold' until the memory answers or the wait budget
// (TIMEOUT cycles in BUSY) runs out. A timed-out read returns 8'hFF and
// raises a sticky error flag.

module mem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        address_read,
    input  logic        data_in,
    input  logic        data_out,
    input  logic        mem_enable,
    input  logic [15:0] bus_in,
    input  logic [7:0]  acc_in,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        hold,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        timeout_err,
    input  logic        err_clr
);

    // Last wait count value allowed before the transaction is abandoned.
    localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rd_data;
    logic [7:0]  r_wait_cnt;
    logic        r_we;
    logic        r_mem_req;
    logic        r_rd_valid;
    logic        r_timeout_err;

    logic        w_valid;
    logic        w_in_idle;
    logic        w_in_busy;
    logic        w_timeout;

    // An access needs exactly one of the read/write qualifiers; both or
    // neither is treated as a malformed request and ignored.
    assign w_valid   = mem_enable & (data_in ^ data_out);
    assign w_in_idle = (r_state == IDLE);
    assign w_in_busy = (r_state == BUSY);

    // Budget exhausted on this cycle; an ack in the same cycle takes priority.
    assign w_timeout = w_in_busy & ~mem_ack & (r_wait_cnt == LP_LAST_WAIT);

    // hold must drop as soon as reset is asserted, even if a request is
    // still being presented, so it is gated by rst_n directly.
    assign hold = rst_n & ((w_in_idle & w_valid) | w_in_busy);

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_we;
    assign rd_data     = r_rd_data;
    assign rd_valid    = r_rd_valid;
    assign timeout_err = r_timeout_err;

    // Address capture from the internal bus; only accepted while idle so an
    // in-flight transaction keeps a stable address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr <= 16'h0000;
        end else if (w_in_idle && address_read) begin
            r_addr <= bus_in;
        end
    end

    // Transaction FSM with registered request, write-enable and read results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_wdata    <= 8'h00;
            r_wait_cnt <= 8'h00;
            r_mem_req  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'h00;
        end else begin
            r_rd_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state    <= BUSY;
                        r_we       <= data_out;
                        r_wdata    <= acc_in;
                        r_wait_cnt <= 8'h00;
                        r_mem_req  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_we      <= 1'b0;
                        if (!r_we) begin
                            r_rd_data  <= mem_rdata;
                            r_rd_valid <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state   <= DONE;
                        r_mem_req <= 1'b0;
                        r_we      <= 1'b0;
                        if (!r_we) begin
                            r_rd_data  <= 8'hFF;
                            r_rd_valid <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'h01;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_we      <= 1'b0;
                end
            endcase
        end
    end

    // Sticky abort flag: a new abort outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (err_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    // The request strobe must track the BUSY state exactly.
    assert property (@(posedge clk) disable iff (!rst_n)
        r_mem_req == (r_state == BUSY));

    // The address presented to memory never moves while a request is pending.
    assert property (@(posedge clk) disable iff (!rst_n)
        (w_in_busy && !mem_ack) |=> $stable(r_addr));

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: a cycle-by-cycle vector table for the
// basic read/write/illegal-access behaviour, plus hand-written sequences for
// timeout, ack-on-last-cycle, back-to-back reads and reset during BUSY.

module tb_mem_bus_ctrl;

    typedef struct packed {
        logic        addrRead;
        logic        dIn;
        logic        dOut;
        logic        en;
        logic [15:0] bus;
        logic [7:0]  acc;
        logic        ack;
        logic [7:0]  rdata;
        logic        clr;
    } in_t;

    typedef struct packed {
        logic        hold;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        rv;
        logic [7:0]  rd;
        logic        err;
    } exp_t;

    typedef struct {
        string name;
        in_t   in;
        exp_t  exp;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        address_read;
    logic        data_in;
    logic        data_out;
    logic        mem_enable;
    logic [15:0] bus_in;
    logic [7:0]  acc_in;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        hold;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        timeout_err;
    logic        err_clr;

    int nApplied = 0;
    int nMiscompare = 0;

    vec_t vecs[18];

    mem_bus_ctrl #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address_read (address_read),
        .data_in      (data_in),
        .data_out     (data_out),
        .mem_enable   (mem_enable),
        .bus_in       (bus_in),
        .acc_in       (acc_in),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .hold         (hold),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the DUT stalls a sequence indefinitely.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic in_t mkIn(input logic addrRead, input logic dIn, input logic dOut,
                                 input logic en, input logic [15:0] bus, input logic [7:0] acc,
                                 input logic ack, input logic [7:0] rdata, input logic clr);
        in_t s;
        s.addrRead = addrRead;
        s.dIn      = dIn;
        s.dOut     = dOut;
        s.en       = en;
        s.bus      = bus;
        s.acc      = acc;
        s.ack      = ack;
        s.rdata    = rdata;
        s.clr      = clr;
        return s;
    endfunction

    function automatic exp_t mkExp(input logic h, input logic rq, input logic w,
                                   input logic [15:0] a, input logic [7:0] wd,
                                   input logic v, input logic [7:0] r, input logic e);
        exp_t x;
        x.hold  = h;
        x.req   = rq;
        x.we    = w;
        x.addr  = a;
        x.wdata = wd;
        x.rv    = v;
        x.rd    = r;
        x.err   = e;
        return x;
    endfunction

    task automatic applyStimulus(input in_t s);
        address_read = s.addrRead;
        data_in      = s.dIn;
        data_out     = s.dOut;
        mem_enable   = s.en;
        bus_in       = s.bus;
        acc_in       = s.acc;
        mem_ack      = s.ack;
        mem_rdata    = s.rdata;
        err_clr      = s.clr;
    endtask

    // Drive one cycle's inputs on the falling edge and settle before checking.
    task automatic stepTo(input in_t s);
        @(negedge clk);
        applyStimulus(s);
        #1;
    endtask

    task automatic checkOutput(input string nm, input exp_t e);
        exp_t a;
        a = mkExp(hold, mem_req, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, timeout_err);
        nApplied++;
        if (a !== e) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got hold=%b req=%b we=%b addr=%h wdata=%h rv=%b rd=%h err=%b, want hold=%b req=%b we=%b addr=%h wdata=%h rv=%b rd=%h err=%b",
                     nm, a.hold, a.req, a.we, a.addr, a.wdata, a.rv, a.rd, a.err,
                     e.hold, e.req, e.we, e.addr, e.wdata, e.rv, e.rd, e.err);
        end
    endtask

    task automatic checkScalar(input string nm, input int actual, input int expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompare++;
            $display("[TB] FAIL %s: got %0d, want %0d", nm, actual, expected);
        end
    endtask

    initial begin
        in_t idleIn;
        in_t readIn;
        in_t clrIn;
        int  busyCycles;

        idleIn = mkIn(0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 0);
        readIn = mkIn(0, 1, 0, 1, 16'h0000, 8'h00, 0, 8'h00, 0);
        clrIn  = mkIn(0, 0, 0, 0, 16'h0000, 8'h00, 0, 8'h00, 1);

        // Each row is one clock cycle: inputs held for the cycle, expected
        // outputs sampled during that same cycle (before the closing edge).
        vecs[0]  = '{"idle",              idleIn,                                               mkExp(0,0,0,16'h0000,8'h00,0,8'h00,0)};
        vecs[1]  = '{"latchAddr",         mkIn(1,0,0,0,16'h1234,8'h00,0,8'h00,0),               mkExp(0,0,0,16'h0000,8'h00,0,8'h00,0)};
        vecs[2]  = '{"readReq",           readIn,                                               mkExp(1,0,0,16'h1234,8'h00,0,8'h00,0)};
        vecs[3]  = '{"readBusyAck",       mkIn(0,0,0,0,16'h0000,8'h00,1,8'h5A,0),               mkExp(1,1,0,16'h1234,8'h00,0,8'h00,0)};
        vecs[4]  = '{"readDone",          idleIn,                                               mkExp(0,0,0,16'h1234,8'h00,1,8'h5A,0)};
        vecs[5]  = '{"idleAfterRead",     idleIn,                                               mkExp(0,0,0,16'h1234,8'h00,0,8'h5A,0)};
        vecs[6]  = '{"writeReq",          mkIn(0,0,1,1,16'h0000,8'hC3,0,8'h00,0),               mkExp(1,0,0,16'h1234,8'h00,0,8'h5A,0)};
        vecs[7]  = '{"writeBusy1",        idleIn,                                               mkExp(1,1,1,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[8]  = '{"writeBusy2AddrRd",  mkIn(1,0,0,0,16'hBEEF,8'h00,0,8'h00,0),               mkExp(1,1,1,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[9]  = '{"writeBusy3",        mkIn(0,0,0,0,16'h0000,8'h00,0,8'h99,0),               mkExp(1,1,1,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[10] = '{"writeBusy4Ack",     mkIn(0,0,0,0,16'h0000,8'h00,1,8'h99,0),               mkExp(1,1,1,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[11] = '{"writeDoneIgnAccess",readIn,                                               mkExp(0,0,0,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[12] = '{"idleNoRestart",     idleIn,                                               mkExp(0,0,0,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[13] = '{"illegalBoth",       mkIn(0,1,1,1,16'h0000,8'h00,0,8'h00,0),               mkExp(0,0,0,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[14] = '{"illegalNeither",    mkIn(0,0,0,1,16'h0000,8'h00,0,8'h00,0),               mkExp(0,0,0,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[15] = '{"ackOutsideBusy",    mkIn(0,0,0,0,16'h0000,8'h00,1,8'h77,0),               mkExp(0,0,0,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[16] = '{"afterStrayAck",     idleIn,                                               mkExp(0,0,0,16'h1234,8'hC3,0,8'h5A,0)};
        vecs[17] = '{"clrNoError",        clrIn,                                                mkExp(0,0,0,16'h1234,8'hC3,0,8'h5A,0)};

        // Reset with a request already presented: hold must still be low.
        rst_n = 1'b0;
        applyStimulus(readIn);
        #23;
        checkOutput("resetState", mkExp(0,0,0,16'h0000,8'h00,0,8'h00,0));
        @(negedge clk);
        applyStimulus(idleIn);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            stepTo(vecs[i].in);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Timeout: read with no ack must give up after 15 BUSY cycles.
        stepTo(readIn);
        checkScalar("toReqHold", hold, 1);
        busyCycles = 0;
        for (int c = 0; c < 40; c++) begin
            stepTo(idleIn);
            if (!mem_req) break;
            busyCycles++;
        end
        checkScalar("toBusyCycles", busyCycles, 15);
        checkOutput("toDone", mkExp(0,0,0,16'h1234,8'h00,1,8'hFF,1));
        stepTo(idleIn);
        checkOutput("toErrSticky", mkExp(0,0,0,16'h1234,8'h00,0,8'hFF,1));
        stepTo(clrIn);
        stepTo(idleIn);
        checkScalar("errCleared", timeout_err, 0);

        // Abort and clear in the same cycle: the abort must win.
        stepTo(readIn);
        for (int c = 0; c < 15; c++) stepTo(clrIn);
        stepTo(idleIn);
        checkOutput("setWinsOverClr", mkExp(0,0,0,16'h1234,8'h00,1,8'hFF,1));
        stepTo(clrIn);
        stepTo(idleIn);
        checkScalar("errCleared2", timeout_err, 0);

        // Ack on the 15th (last allowed) BUSY cycle completes normally.
        stepTo(readIn);
        for (int c = 0; c < 14; c++) stepTo(idleIn);
        stepTo(mkIn(0,0,0,0,16'h0000,8'h00,1,8'h3C,0));
        checkOutput("bndLastBusy", mkExp(1,1,0,16'h1234,8'h00,0,8'hFF,0));
        // Back-to-back: request held from DONE onward is taken only in IDLE.
        stepTo(readIn);
        checkOutput("bndDone", mkExp(0,0,0,16'h1234,8'h00,1,8'h3C,0));
        stepTo(readIn);
        checkOutput("b2bIdleAccept", mkExp(1,0,0,16'h1234,8'h00,0,8'h3C,0));
        stepTo(mkIn(0,0,0,0,16'h0000,8'h00,1,8'hA5,0));
        checkOutput("b2bBusy", mkExp(1,1,0,16'h1234,8'h00,0,8'h3C,0));
        stepTo(idleIn);
        checkOutput("b2bDone", mkExp(0,0,0,16'h1234,8'h00,1,8'hA5,0));

        // Reset in the middle of a read: immediate abort, no DONE pulse.
        stepTo(readIn);
        stepTo(idleIn);
        checkScalar("rstPreBusy", mem_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rstImmediate", mkExp(0,0,0,16'h0000,8'h00,0,8'h00,0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstReleased", mkExp(0,0,0,16'h0000,8'h00,0,8'h00,0));
        stepTo(idleIn);
        checkOutput("rstNoDone1", mkExp(0,0,0,16'h0000,8'h00,0,8'h00,0));
        stepTo(idleIn);
        checkOutput("rstNoDone2", mkExp(0,0,0,16'h0000,8'h00,0,8'h00,0));

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompare);
        $finish;
    end

endmodule
